// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage pipeline: hazard FSM encoding
// and datapath widths.
package cpu_pkg;

  localparam int REG_AW = 4;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HALT = 2'b10,
    ERR  = 2'b11
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare: the ID instruction reads a register the EX load is
// still fetching. r0 is hardwired, so a load to r0 never creates a hazard.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_re1,
  input  logic              id_re2,
  input  logic              ex_ld,
  input  logic [REG_AW-1:0] ex_dst,
  output logic              loadUse
);

  logic hit1;
  logic hit2;

  assign hit1    = id_re1 && (id_src1 == ex_dst);
  assign hit2    = id_re2 && (id_src2 == ex_dst);
  assign loadUse = ex_ld && (ex_dst != '0) && (hit1 || hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer: data-memory wait FSM with timeout, halt freeze,
// branch squash and load-use bubble, plus a saturating stall counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_re1,
  input  logic              id_re2,
  input  logic              ex_ld,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_br_taken,
  input  logic              mem_req,
  input  logic              dmem_rdy,
  input  logic              wb_hlt,
  output logic              stallPC,
  output logic              stallIF,
  output logic              stallID,
  output logic              stallEX,
  output logic              stallMEM,
  output logic              flushIF,
  output logic              flushID,
  output logic              flushEX,
  output logic              flushMEM,
  output logic              halted,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbgState
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  state_t          state;
  state_t          nextState;
  logic [WC_W-1:0] waitCnt;
  logic [WC_W-1:0] nextWait;
  logic            memWait;
  logic            loadUse;

  hazard_detect uDetect (
    .id_src1 (id_src1),
    .id_src2 (id_src2),
    .id_re1  (id_re1),
    .id_re2  (id_re2),
    .ex_ld   (ex_ld),
    .ex_dst  (ex_dst),
    .loadUse (loadUse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWait;
    end
  end

  // Halt in WB wins over a new wait; inside WAIT it is ignored because
  // MEM_WB keeps presenting it until we are back in IDLE.
  always_comb begin
    nextState = state;
    nextWait  = waitCnt;
    case (state)
      IDLE: begin
        if (wb_hlt) begin
          nextState = HALT;
        end else if (mem_req && !dmem_rdy) begin
          nextState = WAIT;
          nextWait  = WC_W'(1);
        end
      end
      WAIT: begin
        if (dmem_rdy) begin
          nextState = IDLE;
          nextWait  = '0;
        end else if (waitCnt == WC_W'(TIMEOUT - 1)) begin
          nextState = ERR;
        end else begin
          nextWait = waitCnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign memWait = ((state == IDLE) && mem_req && !dmem_rdy) ||
                   ((state == WAIT) && !dmem_rdy);

  always_comb begin
    stallPC  = 1'b0;
    stallIF  = 1'b0;
    stallID  = 1'b0;
    stallEX  = 1'b0;
    stallMEM = 1'b0;
    flushIF  = 1'b0;
    flushID  = 1'b0;
    if (!rst_n) begin
      stallPC = 1'b0;
    end else if ((state == HALT) || (state == ERR) || memWait) begin
      // A held branch in EX is re-applied once the freeze lifts.
      stallPC  = 1'b1;
      stallIF  = 1'b1;
      stallID  = 1'b1;
      stallEX  = 1'b1;
      stallMEM = 1'b1;
    end else if (ex_br_taken) begin
      flushIF = 1'b1;
      flushID = 1'b1;
    end else if (loadUse) begin
      stallPC = 1'b1;
      stallIF = 1'b1;
      flushID = 1'b1;
    end
  end

  assign flushEX  = 1'b0;
  assign flushMEM = 1'b0;
  assign halted   = (state == HALT);
  assign mem_err  = (state == ERR);
  assign dbgState = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stallPC && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each driven cycle pushes its expected
// outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int W       = 13 + CNT_W;

  logic             clk;
  logic             rst_n;
  logic [3:0]       id_src1, id_src2, ex_dst;
  logic             id_re1, id_re2, ex_ld, ex_br_taken, mem_req, dmem_rdy, wb_hlt;
  logic             stallPC, stallIF, stallID, stallEX, stallMEM;
  logic             flushIF, flushID, flushEX, flushMEM;
  logic             halted, mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       dbgState;

  logic [W-1:0]     exp_q[$];
  string            name_q[$];
  logic [CNT_W-1:0] sc;
  int               total;
  int               bad;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_src1(id_src1), .id_src2(id_src2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_ld(ex_ld), .ex_dst(ex_dst), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .dmem_rdy(dmem_rdy), .wb_hlt(wb_hlt),
    .stallPC(stallPC), .stallIF(stallIF), .stallID(stallID),
    .stallEX(stallEX), .stallMEM(stallMEM),
    .flushIF(flushIF), .flushID(flushID), .flushEX(flushEX), .flushMEM(flushMEM),
    .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stalls[4:0], flushIF, flushID, flushEX, flushMEM, halted, mem_err, state}
  function automatic logic [12:0] ev(input logic [4:0] s, input logic [1:0] f,
                                     input logic h, input logic e, input logic [1:0] st);
    return {s, f, 2'b00, h, e, st};
  endfunction

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] s1, input logic [3:0] s2, input logic r1,
                        input logic r2, input logic ld, input logic [3:0] dst,
                        input logic br, input logic req, input logic rdy, input logic hlt);
    id_src1 = s1; id_src2 = s2; id_re1 = r1; id_re2 = r2;
    ex_ld = ld; ex_dst = dst; ex_br_taken = br;
    mem_req = req; dmem_rdy = rdy; wb_hlt = hlt;
  endtask

  task automatic idle_in();
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // expected stall_cnt is the count before this cycle; model its increment
  task automatic step(input string nm, input logic [12:0] v);
    exp_q.push_back({v, sc});
    name_q.push_back(nm);
    if (v[12] && (sc != '1)) sc = sc + 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] act;
      logic [W-1:0] exp;
      string        nm;
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {stallPC, stallIF, stallID, stallEX, stallMEM, flushIF, flushID,
             flushEX, flushMEM, halted, mem_err, dbgState, stall_cnt};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
    end
  end

  initial begin
    logic [12:0] zero0, lu, br, allIdle, allWait, allHalt, allErr;
    zero0   = ev(5'b00000, 2'b00, 1'b0, 1'b0, 2'b00);
    lu      = ev(5'b11000, 2'b01, 1'b0, 1'b0, 2'b00);
    br      = ev(5'b00000, 2'b11, 1'b0, 1'b0, 2'b00);
    allIdle = ev(5'b11111, 2'b00, 1'b0, 1'b0, 2'b00);
    allWait = ev(5'b11111, 2'b00, 1'b0, 1'b0, 2'b01);
    allHalt = ev(5'b11111, 2'b00, 1'b1, 1'b0, 2'b10);
    allErr  = ev(5'b11111, 2'b00, 1'b0, 1'b1, 2'b11);
    total = 0; bad = 0; sc = '0;
    rst_n = 1'b0;
    idle_in();

    next_cycle(); step("reset", zero0);
    next_cycle(); rst_n = 1'b1; step("post_reset_idle", zero0);

    // load-use bubbles
    next_cycle(); set_in(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step("load_use_src1", lu);
    next_cycle(); idle_in(); step("load_use_one_cycle", zero0);
    next_cycle(); set_in(4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("load_r0_no_hazard", zero0);
    next_cycle(); set_in(4'd1, 4'd5, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    step("load_use_src2", lu);
    next_cycle(); set_in(4'd5, 4'd5, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    step("load_no_read", zero0);
    next_cycle(); set_in(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    step("branch_beats_load_use", br);

    // memory wait of three cycles, branch held during the wait
    next_cycle(); set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("mem_wait_c1", allIdle);
    next_cycle(); ex_br_taken = 1'b1; step("mem_wait_c2_branch", allWait);
    next_cycle(); step("mem_wait_c3_branch", allWait);
    next_cycle(); dmem_rdy = 1'b1;
    step("mem_done_branch_applies", ev(5'b00000, 2'b11, 1'b0, 1'b0, 2'b01));
    next_cycle(); idle_in(); step("mem_back_idle", zero0);
    next_cycle(); mem_req = 1'b1; dmem_rdy = 1'b1; step("zero_wait_mem", zero0);

    // halt has priority over a new wait, then freezes
    next_cycle(); mem_req = 1'b1; dmem_rdy = 1'b0; wb_hlt = 1'b1;
    step("halt_with_mem_req", allIdle);
    next_cycle(); idle_in(); step("halted_freeze", allHalt);
    next_cycle(); ex_br_taken = 1'b1; step("halted_ignores_branch", allHalt);
    next_cycle(); rst_n = 1'b0; sc = '0; step("reset_from_halt", zero0);
    next_cycle(); rst_n = 1'b1; idle_in(); step("idle_after_halt_reset", zero0);

    // timeout into ERR, then stall_cnt saturation
    next_cycle(); mem_req = 1'b1; dmem_rdy = 1'b0;
    step("timeout_c1", allIdle);
    next_cycle(); step("timeout_c2", allWait);
    next_cycle(); step("timeout_c3", allWait);
    next_cycle(); step("timeout_c4", allWait);
    next_cycle(); step("timeout_err", allErr);
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      mem_req = i[0];
      dmem_rdy = i[1];
      step("err_count_saturate", allErr);
    end
    next_cycle(); rst_n = 1'b0; sc = '0; idle_in(); step("reset_from_err", zero0);
    next_cycle(); rst_n = 1'b1; step("idle_after_err_reset", zero0);

    // asynchronous reset in the middle of a wait
    next_cycle(); mem_req = 1'b1; dmem_rdy = 1'b0; step("wait2_c1", allIdle);
    next_cycle(); step("wait2_c2", allWait);
    next_cycle(); rst_n = 1'b0; sc = '0; step("reset_mid_wait", zero0);
    next_cycle(); rst_n = 1'b1; idle_in(); step("idle_after_wait_reset", zero0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 16-bit 5-stage pipeline (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
- Resolves data-memory wait states, load-use hazards, taken-branch squash and halt, and drives the per-register stall/flush inputs.
- Holds a small FSM for multi-cycle data-memory access, plus a saturating stall-cycle counter for debug.

Parameters:
- TIMEOUT, 64, max consecutive wait cycles for one data-memory access before the block enters ERR.
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_src1, id_src2  in  4 each  source register addresses of the instruction in ID.
- id_re1, id_re2  in  1 each  source 1/2 actually read by the ID instruction.
- ex_ld  in  1  instruction in EX is a load.
- ex_dst  in  4  destination register of the EX instruction.
- ex_br_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  instruction in MEM accesses data memory.
- dmem_rdy  in  1  data memory completes the access this cycle.
- wb_hlt  in  1  hltOut of MEM_WB (halt reached WB).
- stallPC, stallIF, stallID, stallEX, stallMEM  out  1 each  hold PC / IF_ID / ID_EX / EX_MEM / MEM_WB.
- flushIF, flushID, flushEX, flushMEM  out  1 each  bubble into IF_ID / ID_EX / EX_MEM / MEM_WB.
- halted  out  1  pipeline permanently frozen by halt.
- mem_err  out  1  data-memory timeout, sticky.
- stall_cnt  out  CNT_W  saturating count of cycles with stallPC=1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wait_cnt=0, stall_cnt=0, halted=0, mem_err=0.
  - All stall/flush outputs are 0 while in reset.
- FSM states:
  - IDLE:
    - mem_req & !dmem_rdy -> WAIT, wait_cnt=1.
    - wb_hlt -> HALT. wb_hlt has priority over a new memory wait.
  - WAIT:
    - dmem_rdy -> IDLE, wait_cnt=0.
    - Otherwise wait_cnt+1. wait_cnt==TIMEOUT-1 with !dmem_rdy -> ERR.
    - wb_hlt is ignored in WAIT. It is re-evaluated in IDLE because MEM_WB holds it.
  - HALT: absorbing until reset; halted=1.
  - ERR: absorbing until reset; mem_err=1.
- mem_wait (combinational) = (state==IDLE & mem_req & !dmem_rdy) | (state==WAIT & !dmem_rdy). Zero-wait memory (dmem_rdy=1 on first cycle) causes no stall.
- Output priority, highest first; outputs are combinational from state and inputs:
  1. HALT or ERR: all five stall outputs=1, all flush outputs=0.
  2. mem_wait: all five stall outputs=1, flushes=0. MEM_WB re-presents the same write each cycle, which is idempotent.
  3. ex_br_taken: flushIF=1, flushID=1, stalls=0. This kills the two wrong-path instructions.
  4. load-use: stallPC=1, stallIF=1, flushID=1.
     - Condition: ex_ld & ex_dst!=0 & ((id_re1 & id_src1==ex_dst) | (id_re2 & id_src2==ex_dst)).
     - Exactly one bubble per hazard, because on the next cycle the load has moved to MEM.
  5. Otherwise all stall/flush outputs=0.
- Simultaneous events:
  - Branch + load-use in the same cycle: branch wins, no stall.
  - mem_wait + branch: stall only; the branch is re-applied once the wait ends, because EX is held.
- flushEX and flushMEM are reserved outputs, tied 0 in this revision.
- stall_cnt increments on every cycle with stallPC=1 and saturates at all-ones. It keeps counting in HALT and ERR.
- Reset asserted mid-WAIT or in HALT/ERR returns to IDLE immediately (asynchronous); counters clear.

Decomposition:
- Shared package cpu_pkg holds:
  - FSM state encoding (IDLE=2'b00, WAIT=2'b01, HALT=2'b10, ERR=2'b11).
  - Register-address width (4) and data width (16).
- Natural sub-module: hazard_detect, a purely combinational load-use compare. FSM, priority mux and counters stay in the top.

Test Plan:
- Load-use: ex_ld=1, ex_dst=3, id_src1=3, id_re1=1 for one cycle -> stallPC=stallIF=flushID=1 that cycle only. With ex_dst=0 -> no stall.
- Memory wait: mem_req=1, dmem_rdy low for 3 cycles then high -> all stalls=1 for exactly 3 cycles, state IDLE->WAIT->IDLE, stall_cnt=3.
- Branch during load-use: ex_br_taken=1 with load-use condition true -> flushIF=flushID=1, stallPC=0.
- Halt: wb_hlt=1 in IDLE -> next cycle halted=1, all stalls=1. They persist with wb_hlt=0 until rst_n pulses low.
- Timeout: mem_req=1, dmem_rdy=0 for TIMEOUT cycles (TIMEOUT=4) -> mem_err=1 on cycle 5, all stalls stay 1. rst_n low mid-WAIT -> all outputs 0 immediately, stall_cnt=0.
- Saturation: CNT_W=4, hold a memory wait for 20 cycles -> stall_cnt sticks at 15.
